// File: rtl/matrix_pkg.sv
// matrix_pkg: shared geometry and scan-state type for the LED matrix scanner
package matrix_pkg;
  localparam int NUM_LINES = 4;
  localparam int LINE_WIDTH = 8;
  typedef enum logic {SCAN, BLANK} scan_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round robin, the writer not granted most recently wins a tie
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic prio_b;
  always_comb begin
    gnt_a = en && req_a && (!req_b || !prio_b);
    gnt_b = en && req_b && (!req_a || prio_b);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) prio_b <= 1'b0;
    else if (gnt_a || gnt_b) prio_b <= gnt_a;
endmodule

// File: rtl/matrix_scan_arbiter.sv
// matrix_scan_arbiter: double-buffered 4x8 LED matrix scanner with two arbitrated writers
module matrix_scan_arbiter
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic [1:0]            addr_a,
  input  logic [LINE_WIDTH-1:0] data_a,
  output logic                  gnt_a,
  input  logic                  req_b,
  input  logic [1:0]            addr_b,
  input  logic [LINE_WIDTH-1:0] data_b,
  output logic                  gnt_b,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  frame_start,
  output logic [LINE_WIDTH-1:0] led_r,
  output logic [NUM_LINES-1:0]  led_c
);
  localparam int CW = $clog2(DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES);
  scan_state_t state, state_nxt;
  logic [1:0] line, line_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [NUM_LINES-1:0][LINE_WIDTH-1:0] front, back, front_nxt, back_nxt;
  logic boundary, swap;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (!swap_ack && !rst),
    .req_a (req_a),
    .req_b (req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );
  always_comb begin
    state_nxt = state;
    line_nxt = line;
    cnt_nxt = cnt + CW'(1);
    if (state == SCAN && cnt == CW'(DWELL_CYCLES - 1)) begin
      state_nxt = BLANK;
      cnt_nxt = '0;
    end else if (state == BLANK && cnt == CW'(BLANK_CYCLES - 1)) begin
      state_nxt = SCAN;
      line_nxt = line + 2'd1;
      cnt_nxt = '0;
    end
    boundary = state == BLANK && state_nxt == SCAN && line == 2'd3;
    swap = boundary && swap_req;
    back_nxt = back;
    if (gnt_a) back_nxt[addr_a] = data_a;
    if (gnt_b) back_nxt[addr_b] = data_b;
    // a write landing on the swap edge must reach the new front as well
    front_nxt = swap ? back_nxt : front;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= BLANK;
      line <= 2'd3;
      cnt <= '0;
      front <= '0;
      back <= '0;
      frame_start <= 1'b0;
      swap_ack <= 1'b0;
      led_r <= '1;
      led_c <= '1;
    end else begin
      state <= state_nxt;
      line <= line_nxt;
      cnt <= cnt_nxt;
      front <= front_nxt;
      back <= back_nxt;
      frame_start <= boundary;
      swap_ack <= swap;
      led_r <= state_nxt == SCAN ? ~front_nxt[line_nxt] : '1;
      led_c <= state_nxt == SCAN ? ~(NUM_LINES'(1) << line_nxt) : '1;
    end
endmodule
